// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller state: read outstanding or not, and whether it is kept
  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no outstanding read
    BUSY = 2'd1,   // outstanding read, data will be buffered
    DROP = 2'd2    // outstanding read, data will be discarded
  } fetch_state_e;

  // Byte distance between consecutive 16-bit instructions
  localparam logic [15:0] PC_STEP = 16'd2;

  // One buffered instruction together with the address it came from
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } instr_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO with single-edge flush. The head entry is
//            read straight from the storage array by a registered pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO only accepts a push when the head leaves on the same edge
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array: written at the tail, no reset needed on data
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one edge
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues reads to a variable-latency
//            instruction memory, buffers returned words with their PC and
//            hands them to the datapath over valid/ready. A redirect flushes
//            the buffer and discards any read already in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  logic          r_mem_req;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_fetch_pc;

  logic [15:0]   w_redir_pc;
  logic [15:0]   w_pc_inc;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_space;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  instr_entry_t  w_wentry;
  instr_entry_t  w_head;

  assign w_redir_pc = {redirect_pc[15:1], 1'b0};
  assign w_pc_inc   = r_fetch_pc + PC_STEP;
  assign w_flush    = redirect_valid;
  // Only a kept read pushes; a same-cycle redirect discards the ack data
  assign w_push     = (r_state == BUSY) && mem_ack && !redirect_valid && (!w_full || w_pop);
  // Redirect wins over consumption: the head is not counted as taken
  assign w_pop      = !w_empty && instr_ready && !redirect_valid;
  assign w_wentry   = '{pc: r_fetch_pc, word: mem_rdata};

  // Occupancy after this edge's flush/push/pop, used to decide if a new read fits
  always_comb begin
    w_count_next = w_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = w_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - CW'(1);
    end
  end

  assign w_space = (w_count_next < CW'(DEPTH));

  // Fetch controller: request issue, PC sequencing and in-flight discard
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_mem_addr <= w_redir_pc;
            r_mem_req  <= 1'b1;
            r_state    <= BUSY;
          end else if (w_space) begin
            r_mem_addr <= r_fetch_pc;
            r_mem_req  <= 1'b1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack && redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_mem_addr <= w_redir_pc;
          end else if (mem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_space) begin
              r_mem_addr <= w_pc_inc;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end
          end else if (redirect_valid) begin
            // The read cannot be withdrawn; wait out its ack and drop it
            r_fetch_pc <= w_redir_pc;
            r_state    <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            r_state <= BUSY;
            if (redirect_valid) begin
              r_fetch_pc <= w_redir_pc;
              r_mem_addr <= w_redir_pc;
            end else begin
              r_mem_addr <= r_fetch_pc;
            end
          end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(instr_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = !w_empty;
  assign instr       = w_head.word;
  assign instr_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomised self-checking bench for fetch_unit with a memory
//            responder and a scoreboard of the instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct { logic [15:0] pc; logic [15:0] word; } exp_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        instr_ready = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs
  int          lat_mode   = 0;     // <0: random 0..3 cycles, else fixed
  int          ready_mode = 1;     // 0 low, 1 high, 2 random
  bit          rand_redir = 1'b0;
  int          dir_mode   = 0;     // directed redirect trigger
  logic [15:0] dir_pc     = 16'h0;
  bit          dir_hit    = 1'b0;

  // memory responder state
  bit          busy = 1'b0;
  int          cnt  = 0;
  logic [15:0] start_addr = 16'h0;
  int          n_acks = 0;

  // scoreboard state
  exp_entry_t  q[$];
  logic [15:0] cap[$];
  logic [15:0] exp_pc = RESET_PC;
  bit          tainted = 1'b0;
  int          n_pops = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder, ready and redirect driver: inputs change 1 time unit after the edge
  always @(posedge clk) begin
    bit ack_now;
    bit started;
    #1;
    ack_now        = 1'b0;
    started        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'($urandom);
    if (rst) begin
      busy = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy       = 1'b1;
        started    = 1'b1;
        start_addr = mem_addr;
        cnt        = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else begin
        check_val("addr_hold", {16'h0, mem_addr}, {16'h0, start_addr});
      end
      if (cnt == 0) begin
        ack_now = 1'b1;
        busy    = 1'b0;
        n_acks++;
      end else begin
        cnt--;
      end
    end
    mem_ack   = ack_now;
    mem_rdata = ack_now ? (mem_addr ^ 16'hA5A5) : 16'($urandom);
    case (ready_mode)
      0:       instr_ready = 1'b0;
      1:       instr_ready = 1'b1;
      default: instr_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (!rst) begin
      if (rand_redir && ($urandom_range(0, 19) == 0)) redirect_valid = 1'b1;
      if ((dir_mode == 1 && mem_req && !started && start_addr == 16'h0006) ||
          (dir_mode == 2 && ack_now && instr_valid) ||
          (dir_mode == 3 && ack_now)) begin
        redirect_valid = 1'b1;
        redirect_pc    = dir_pc;
        dir_mode       = 0;
        dir_hit        = 1'b1;
      end
    end
  end

  // Scoreboard: check current outputs, then advance the model across the coming edge
  always @(negedge clk) begin
    bit pop;
    bit kept;
    if (rst) begin
      q.delete();
      exp_pc  = RESET_PC;
      tainted = 1'b0;
    end else begin
      check_val("valid", {31'h0, instr_valid}, {31'h0, (q.size() != 0)});
      if (q.size() != 0) begin
        check_val("head_pc",   {16'h0, instr_pc}, {16'h0, q[0].pc});
        check_val("head_word", {16'h0, instr},    {16'h0, q[0].word});
      end
      check_val("addr_bit0", {31'h0, mem_addr[0]}, 32'h0);
      pop  = instr_valid && instr_ready && !redirect_valid;
      kept = mem_req && mem_ack && !tainted && !redirect_valid;
      if (kept) check_val("fetch_order", {16'h0, mem_addr}, {16'h0, exp_pc});
      if (redirect_valid) begin
        q.delete();
        cap.delete();
        exp_pc  = {redirect_pc[15:1], 1'b0};
        tainted = mem_req && !mem_ack;
      end else begin
        if (pop && q.size() != 0) begin
          cap.push_back(instr_pc);
          void'(q.pop_front());
          n_pops++;
        end
        if (kept) begin
          q.push_back('{pc: mem_addr, word: mem_rdata});
          exp_pc = exp_pc + 16'd2;
        end
        if (mem_req && mem_ack) tainted = 1'b0;
      end
      check_val("occupancy", {31'h0, (q.size() <= DEPTH)}, 32'h1);
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("rst_req",   {31'h0, mem_req},     32'h0);
    check_val("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_val("rst_addr",  {16'h0, mem_addr},    {16'h0, RESET_PC});
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) return;
    end
    check_val("wait_req_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_dir();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dir_hit) return;
    end
    check_val("wait_redirect_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic [15:0] wrap_pcs [4];
    bit          found;

    // Streaming with single-cycle acks
    do_reset(2);
    lat_mode = 0; ready_mode = 1;
    repeat (20) @(posedge clk);

    // Backpressure: FIFO fills, fetch stalls, then resumes at 8
    ready_mode = 0;
    do_reset(1);
    n_acks = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_val("stall_acks",  n_acks,                 32'd4);
    check_val("stall_req",   {31'h0, mem_req},       32'h0);
    check_val("stall_valid", {31'h0, instr_valid},   32'h1);
    ready_mode = 1;
    wait_req();
    check_val("resume_addr", {16'h0, mem_addr}, 32'h0008);

    // Redirect while read to 6 is in flight with 3-cycle latency
    do_reset(1);
    lat_mode = 3; dir_pc = 16'h0040; dir_hit = 1'b0; dir_mode = 1;
    wait_dir();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_addr != 16'h0006) found = 1'b1;
    end
    check_val("drop_next_addr", {16'h0, mem_addr}, 32'h0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    check_val("drop_first_pc", {16'h0, instr_pc}, 32'h0040);

    // Redirect to an odd PC together with an ack and a pop
    lat_mode = 0;
    repeat (6) @(posedge clk);
    dir_pc = 16'h0101; dir_hit = 1'b0; dir_mode = 2;
    wait_dir();
    @(negedge clk);
    check_val("odd_flush_valid", {31'h0, instr_valid}, 32'h0);
    check_val("odd_addr",        {16'h0, mem_addr},    32'h0100);

    // PC wraparound across 16'hFFFE
    dir_pc = 16'hFFFC; dir_hit = 1'b0; dir_mode = 3;
    wait_dir();
    repeat (10) @(negedge clk);
    wrap_pcs = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("wrap_pc%0d", i),
                {16'h0, (i < cap.size()) ? cap[i] : 16'hDEAD}, {16'h0, wrap_pcs[i]});
    end

    // Reset while a read is waiting for its ack
    lat_mode = 10;
    repeat (3) @(negedge clk);
    check_val("pre_rst_req", {31'h0, mem_req}, 32'h1);
    lat_mode = 0;
    do_reset(1);
    wait_req();
    check_val("post_rst_addr", {16'h0, mem_addr}, {16'h0, RESET_PC});

    // Random latency, backpressure and redirects
    lat_mode = -1; ready_mode = 2; rand_redir = 1'b1;
    repeat (3000) @(posedge clk);
    rand_redir = 1'b0;
    @(negedge clk);
    check_val("progress", {31'h0, (n_pops > 200)}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
